// File: rtl/mem_sched_if.sv
// rtl/mem_sched_if.sv - requester port bundle shared by the core and host sides of mem_sched
interface mem_sched_if #(
    parameter int AW = 16,
    parameter int DW = 8
);
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          ack;
    logic [DW-1:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - single-port RAM scheduler between core and host with cpustate gating and starvation limit
module mem_sched #(
    parameter int AW         = 16,
    parameter int DW         = 8,
    parameter int STARVE_LIM = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [1:0]    cpustate,
    mem_sched_if.slave    core,
    mem_sched_if.slave    host,
    output logic          ram_en,
    output logic          ram_we,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_wdata,
    input  logic [DW-1:0] ram_rdata,
    output logic          owner,
    output logic          busy
);
    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DONE} state_t;

    localparam logic [3:0] LIM = 4'(STARVE_LIM);

    state_t        state, state_nxt;
    logic [3:0]    streak;
    logic          core_ack_q, host_ack_q, op_we;
    logic [DW-1:0] core_hold, host_hold;
    logic          core_elig, host_elig, grant, host_win;

    always_comb begin
        core_elig = (cpustate == 2'b11) && core.req;
        host_elig = (cpustate != 2'b00) && host.req;
        host_win  = host_elig && (!core_elig || streak == LIM);
        grant     = core_elig || host_elig;
        state_nxt = state;
        case (state)
            S_IDLE:  if (grant) state_nxt = S_ISSUE;
            S_ISSUE: state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ram_en     <= 1'b0;
            ram_we     <= 1'b0;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            owner      <= 1'b0;
            busy       <= 1'b0;
            op_we      <= 1'b0;
            core_ack_q <= 1'b0;
            host_ack_q <= 1'b0;
            core_hold  <= '0;
            host_hold  <= '0;
            streak     <= '0;
        end else begin
            case (state)
                S_IDLE: if (grant) begin
                    owner     <= host_win;
                    ram_en    <= 1'b1;
                    busy      <= 1'b1;
                    ram_we    <= host_win ? host.we    : core.we;
                    op_we     <= host_win ? host.we    : core.we;
                    ram_addr  <= host_win ? host.addr  : core.addr;
                    ram_wdata <= host_win ? host.wdata : core.wdata;
                    // Only a core win over a waiting host counts toward starvation.
                    if (host_win || !host.req) streak <= '0;
                    else if (streak < LIM)     streak <= streak + 4'd1;
                end
                S_ISSUE: begin
                    ram_en     <= 1'b0;
                    ram_we     <= 1'b0;
                    core_ack_q <= !owner;
                    host_ack_q <= owner;
                end
                S_DONE: begin
                    core_ack_q <= 1'b0;
                    host_ack_q <= 1'b0;
                    busy       <= 1'b0;
                    if (owner) host_hold <= ram_rdata;
                    else       core_hold <= ram_rdata;
                end
                default: ;
            endcase
        end
    end

    assign core.ack   = core_ack_q;
    assign host.ack   = host_ack_q;
    // Reads complete a cycle early by passing the RAM output straight through in DONE.
    assign core.rdata = (state == S_DONE && !owner && !op_we) ? ram_rdata : core_hold;
    assign host.rdata = (state == S_DONE &&  owner && !op_we) ? ram_rdata : host_hold;
endmodule

// File: tb/tb_mem_sched.sv
// tb/tb_mem_sched.sv - directed self-checking bench for mem_sched
module tb_mem_sched;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  cpustate = 2'b00;
    logic        ram_en, ram_we, owner, busy;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic [7:0]  mem [0:255];
    logic        prev_en = 1'b0;
    int          total = 0;
    int          bad = 0;

    mem_sched_if #(.AW(16), .DW(8)) core_if ();
    mem_sched_if #(.AW(16), .DW(8)) host_if ();

    mem_sched #(.AW(16), .DW(8), .STARVE_LIM(4)) dut (
        .clk(clk), .rst(rst), .cpustate(cpustate),
        .core(core_if), .host(host_if),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
        .owner(owner), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (!rst) begin
            mem[8'h03] <= 8'h3C;
            mem[8'h20] <= 8'h55;
            mem[8'h21] <= 8'hAA;
        end else if (ram_en) begin
            if (ram_we) mem[ram_addr[7:0]] <= ram_wdata;
            ram_rdata <= mem[ram_addr[7:0]];
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            total++;
            assert (!(core_if.ack && host_if.ack)) else begin
                bad++;
                $error("FAIL both_acks observed=1 expected=0");
            end
            total++;
            assert (!(prev_en && ram_en)) else begin
                bad++;
                $error("FAIL ram_en_back_to_back observed=1 expected=0");
            end
        end
        prev_en = ram_en;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        core_if.req = 0; core_if.we = 0; core_if.addr = '0; core_if.wdata = '0;
        host_if.req = 0; host_if.we = 0; host_if.addr = '0; host_if.wdata = '0;
        tick(2);
        chk("rst_ram_en", ram_en, 0);
        chk("rst_busy", busy, 0);
        chk("rst_owner", owner, 0);
        chk("rst_core_rdata", core_if.rdata, 0);
        chk("rst_host_rdata", host_if.rdata, 0);
        rst = 1;
        tick();

        // host load in IN, with a core request that must be ignored
        cpustate = 2'b01;
        host_if.req = 1; host_if.we = 1; host_if.addr = 16'h0010; host_if.wdata = 8'hA5;
        core_if.req = 1; core_if.we = 0; core_if.addr = 16'h0010;
        tick();
        chk("ld_wr_en", ram_en, 1);
        chk("ld_wr_we", ram_we, 1);
        chk("ld_wr_addr", ram_addr, 16'h0010);
        chk("ld_wr_data", ram_wdata, 8'hA5);
        chk("ld_wr_owner", owner, 1);
        chk("ld_wr_busy", busy, 1);
        tick();
        chk("ld_wr_hack", host_if.ack, 1);
        chk("ld_wr_cack", core_if.ack, 0);
        chk("ld_wr_en_off", ram_en, 0);
        host_if.we = 0;
        tick();
        chk("ld_idle_hack", host_if.ack, 0);
        chk("ld_idle_busy", busy, 0);
        tick();
        chk("ld_rd_en", ram_en, 1);
        chk("ld_rd_we", ram_we, 0);
        tick();
        chk("ld_rd_hack", host_if.ack, 1);
        chk("ld_rd_data", host_if.rdata, 8'hA5);
        host_if.req = 0;
        tick();
        chk("ld_rd_hold", host_if.rdata, 8'hA5);
        chk("ld_core_ign", core_if.ack, 0);
        tick(2);
        chk("ld_core_ign_en", ram_en, 0);

        // RUN: core held, host waiting; every fifth grant goes to host
        cpustate = 2'b11;
        core_if.req = 1; core_if.we = 0; core_if.addr = 16'h0020;
        host_if.req = 1; host_if.we = 0; host_if.addr = 16'h0021;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("run%0d_en", i), ram_en, 1);
            chk($sformatf("run%0d_owner", i), owner, (i % 5 == 4));
            chk($sformatf("run%0d_addr", i), ram_addr, (i % 5 == 4) ? 16'h0021 : 16'h0020);
            tick();
            chk($sformatf("run%0d_cack", i), core_if.ack, (i % 5 != 4));
            chk($sformatf("run%0d_hack", i), host_if.ack, (i % 5 == 4));
            chk($sformatf("run%0d_crd", i), core_if.rdata, 8'h55);
            if (i % 5 == 4) chk($sformatf("run%0d_hrd", i), host_if.rdata, 8'hAA);
            else if (i < 4) chk($sformatf("run%0d_hold", i), host_if.rdata, 8'hA5);
            tick();
            chk($sformatf("run%0d_idle", i), busy, 0);
        end

        // mode change during ISSUE of a core read
        host_if.req = 0;
        core_if.addr = 16'h0003;
        tick();
        chk("mc_owner", owner, 0);
        chk("mc_en", ram_en, 1);
        cpustate = 2'b01;
        tick();
        chk("mc_cack", core_if.ack, 1);
        chk("mc_crd", core_if.rdata, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("mc_ign%0d_en", i), ram_en, 0);
            chk($sformatf("mc_ign%0d_cack", i), core_if.ack, 0);
        end
        chk("mc_hold", core_if.rdata, 8'h3C);

        // cpustate 00 blocks everything
        cpustate = 2'b00;
        host_if.req = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk($sformatf("off%0d_en", i), ram_en, 0);
            chk($sformatf("off%0d_busy", i), busy, 0);
            chk($sformatf("off%0d_acks", i), {core_if.ack, host_if.ack}, 2'b00);
        end

        // asynchronous reset in the middle of ISSUE
        cpustate = 2'b11;
        host_if.req = 0;
        core_if.addr = 16'h0020;
        tick();
        chk("ar_pre_en", ram_en, 1);
        rst = 0;
        #1;
        chk("ar_en", ram_en, 0);
        chk("ar_acks", {core_if.ack, host_if.ack}, 2'b00);
        chk("ar_busy", busy, 0);
        chk("ar_addr", ram_addr, 0);
        chk("ar_crd", core_if.rdata, 0);
        chk("ar_hrd", host_if.rdata, 0);
        core_if.req = 0;
        tick();
        chk("ar_hold_acks", {core_if.ack, host_if.ack}, 2'b00);
        rst = 1;
        tick(2);
        chk("ar_post_busy", busy, 0);
        chk("ar_post_en", ram_en, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
